// File: rtl/gcd_pkg.sv
// ============================================================================
//  Module      : gcd_pkg
//  Description : Shared types and defaults for the subtractive GCD engine.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package gcd_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : gcd_pkg

`default_nettype wire

// File: rtl/gcd_engine_if.sv
// ============================================================================
//  Module      : gcd_engine_if
//  Description : Operand/result handshake bundle; iter_cnt exists only when
//                GCD_ITER_COUNT_EN is defined.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface gcd_engine_if #(
    parameter int WIDTH = gcd_pkg::DEFAULT_WIDTH,
    parameter int CNT_W = gcd_pkg::DEFAULT_CNT_W
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_gcd;
    logic             out_zero;

    if (WIDTH < 2 || CNT_W < 1) begin : g_param_check
        $error("gcd_engine_if: WIDTH must be >= 2 and CNT_W >= 1");
    end

`ifdef GCD_ITER_COUNT_EN
    logic [CNT_W-1:0] iter_cnt;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_gcd, out_zero, iter_cnt
    );
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_gcd, out_zero, iter_cnt
    );
`else
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_gcd, out_zero
    );
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_gcd, out_zero
    );
`endif

endinterface : gcd_engine_if

`default_nettype wire

// File: rtl/gcd_step.sv
// ============================================================================
//  Module      : gcd_step
//  Description : One combinational subtractive-Euclid decision on (A,B).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module gcd_step #(
    parameter int WIDTH = gcd_pkg::DEFAULT_WIDTH
) (
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    output logic      [WIDTH-1:0] o_a_nxt,
    output logic      [WIDTH-1:0] o_b_nxt,
    output logic                  o_zero,
    output logic                  o_eq,
    output logic                  o_stepped
);

    always_comb begin
        o_zero    = (i_a == '0) || (i_b == '0);
        o_eq      = (i_a == i_b);
        o_stepped = !o_zero && !o_eq;
        o_a_nxt   = i_a;
        o_b_nxt   = i_b;
        // Only larger-minus-smaller is ever taken, so no underflow is possible.
        if (o_stepped) begin
            if (i_a > i_b) o_a_nxt = i_a - i_b;
            else           o_b_nxt = i_b - i_a;
        end
    end

endmodule : gcd_step

`default_nettype wire

// File: rtl/gcd_engine.sv
// ============================================================================
//  Module      : gcd_engine
//  Description : Subtractive-Euclid GCD engine, valid/ready on both sides.
//                Optional saturating step counter under GCD_ITER_COUNT_EN.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  wire logic  clk,
    input  wire logic  rst,
    gcd_engine_if.slave bus
);

    if (WIDTH < 2 || CNT_W < 1) begin : g_param_check
        $error("gcd_engine: WIDTH must be >= 2 and CNT_W >= 1");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic             w_zero;
    logic             w_eq;
    logic             w_stepped;

`ifdef GCD_ITER_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    gcd_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_a       (a_q),
        .i_b       (b_q),
        .o_a_nxt   (w_a_nxt),
        .o_b_nxt   (w_b_nxt),
        .o_zero    (w_zero),
        .o_eq      (w_eq),
        .o_stepped (w_stepped)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        gcd_d   = gcd_q;
        zero_d  = zero_q;
        valid_d = valid_q;
`ifdef GCD_ITER_COUNT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    state_d = CALC;
`ifdef GCD_ITER_COUNT_EN
                    cnt_d   = '0;
`endif
                end
            end
            CALC: begin
                // Zero test outranks equality so gcd(0,0) reports out_zero.
                if (w_zero) begin
                    gcd_d   = a_q | b_q;
                    zero_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else if (w_eq) begin
                    gcd_d   = a_q;
                    zero_d  = 1'b0;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else if (w_stepped) begin
                    a_d = w_a_nxt;
                    b_d = w_b_nxt;
`ifdef GCD_ITER_COUNT_EN
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
`endif
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            gcd_q   <= '0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef GCD_ITER_COUNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gcd_q   <= gcd_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
`ifdef GCD_ITER_COUNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = valid_q;
    assign bus.out_gcd   = gcd_q;
    assign bus.out_zero  = zero_q;
`ifdef GCD_ITER_COUNT_EN
    assign bus.iter_cnt  = cnt_q;
`endif

endmodule : gcd_engine

`default_nettype wire
